// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32 load/store path.
//   F3_*          funct3 width/sign codes for loads and stores
//   lsu_state_e   load/store unit FSM states
//   byte_enables  byte-lane mask for an access of the given size and low address bits
package rv32_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } lsu_state_e;

   // size is funct3[1:0] (00 byte, 01 half, 10 word); lane is addr[1:0].
   function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
      logic [3:0] be;
      case (size)
         2'b00:   be = 4'b0001 << lane;
         2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit.
//   st_size   in   2   store size (funct3[1:0])
//   st_data   in   32  rs2 value
//   st_wdata  out  32  store data replicated onto every lane it may land in
//   ld_funct3 in   3   load width/sign code
//   ld_lane   in   2   byte offset of the load (addr[1:0])
//   ld_rdata  in   32  aligned memory word
//   ld_value  out  32  selected lane, sign- or zero-extended
module lsu_align
   import rv32_mem_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [31:0] st_data,
   output logic [31:0] st_wdata,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_lane,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_value
);

   logic [31:0] shifted;

   // Replication lets byte enables alone pick the written lane.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      st_wdata = st_data;
      case (st_size)
         2'b00:   st_wdata = {4{st_data[7:0]}};
         2'b01:   st_wdata = {2{st_data[15:0]}};
         default: st_wdata = st_data;
      endcase
   end

   // Bring the addressed lane down to bit 0, then extend it.
   assign shifted = ld_rdata >> {ld_lane, 3'b000};

   always_comb begin
      ld_value = shifted;
      case (ld_funct3)
         F3_B:    ld_value = {{24{shifted[7]}},  shifted[7:0]};
         F3_H:    ld_value = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   ld_value = {24'd0, shifted[7:0]};
         F3_HU:   ld_value = {16'd0, shifted[15:0]};
         default: ld_value = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between register-read/ALU and data memory. Accepts one request
// in IDLE, issues a held word-aligned memory request, and reports completion with
// a one-cycle done pulse; misaligned, illegal and timed-out accesses end with err.
//   clock, reset             rising-edge clock, async active-high reset
//   lsu_valid/lsu_ready      request handshake (ready only in IDLE)
//   is_load, is_store        operation type
//   funct3, addr, store_data request fields
//   load_data, done, err     completion result
//   mem_req/we/addr/be/wdata memory request, held until mem_ack
//   mem_ack, mem_rdata       memory response
module load_store_unit
   import rv32_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        lsu_valid,
   output logic        lsu_ready,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic        done,
   output logic        err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   lsu_state_e  state;
   logic [CW-1:0] wait_cnt;
   logic [2:0]  op_funct3;
   logic [1:0]  op_lane;
   logic        op_load;
   logic        legal;
   logic        aligned;
   logic [31:0] st_wdata;
   logic [31:0] ld_value;

   always_comb begin
      legal = 1'b0;
      if (is_load && !is_store)
         legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
      else if (is_store && !is_load)
         legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
   end

   // Only funct3[1:0] decides size; illegal codes are rejected by 'legal' anyway.
   assign aligned = (funct3[1:0] == 2'b01) ? !addr[0] :
                    (funct3[1:0] == 2'b10) ? (addr[1:0] == 2'b00) : 1'b1;

   lsu_align u_align (
      .st_size   (funct3[1:0]),
      .st_data   (store_data),
      .st_wdata  (st_wdata),
      .ld_funct3 (op_funct3),
      .ld_lane   (op_lane),
      .ld_rdata  (mem_rdata),
      .ld_value  (ld_value)
   );

   // NOTE: all state and registered outputs use <= so each flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         wait_cnt  <= '0;
         op_funct3 <= '0;
         op_lane   <= '0;
         op_load   <= 1'b0;
         lsu_ready <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
         load_data <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (lsu_valid) begin
                  lsu_ready <= 1'b0;
                  op_funct3 <= funct3;
                  op_lane   <= addr[1:0];
                  op_load   <= is_load;
                  wait_cnt  <= '0;
                  if (legal && aligned) begin
                     state     <= ST_ACCESS;
                     mem_req   <= 1'b1;
                     mem_we    <= is_store;
                     mem_addr  <= {addr[31:2], 2'b00};
                     mem_be    <= byte_enables(funct3[1:0], addr[1:0]);
                     mem_wdata <= is_store ? st_wdata : 32'd0;
                  end else begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end
               end
            end
            ST_ACCESS: begin
               wait_cnt <= wait_cnt + 1'b1;
               // An ack in the cycle the counter would reach the limit still wins.
               if (mem_ack || wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  state     <= ST_DONE;
                  done      <= 1'b1;
                  err       <= !mem_ack;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= '0;
                  mem_be    <= '0;
                  mem_wdata <= '0;
                  if (mem_ack && op_load)
                     load_data <= ld_value;
               end
            end
            default: begin
               state     <= ST_IDLE;
               err       <= 1'b0;
               lsu_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
